// File: rtl/copro_op_sequencer.sv
// Issue-side sequencer for the crypto coprocessor: accepts one decoded
// instruction, steps the shared round datapath, then holds the result.
// Ports:
//   issue_*  : decoded instruction in (valid/ready), kill_i flushes it
//   dp_*     : round datapath control (start/abort pulses, round, last, done)
//   result_* : registered writeback bundle (valid/ready)
//   ops_done_o : count of result handshakes, wraps modulo 2^32
module copro_op_sequencer #(
  parameter int XLEN          = 32,
  parameter int ID_W          = 3,
  parameter int ASCON_ROUNDS  = 12,
  parameter int CHACHA_ROUNDS = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [3:0]      issue_opcode_i,
  input  logic [ID_W-1:0] issue_id_i,
  input  logic [4:0]      issue_rd_i,
  input  logic            kill_i,
  output logic            dp_start_o,
  output logic [3:0]      dp_opcode_o,
  output logic [3:0]      dp_round_o,
  output logic            dp_last_o,
  output logic            dp_abort_o,
  input  logic            dp_done_i,
  input  logic [XLEN-1:0] dp_result_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [4:0]      result_rd_o,
  output logic            result_we_o,
  output logic            result_exc_o,
  output logic [XLEN-1:0] result_data_o,
  output logic [31:0]     ops_done_o
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'd1;
  localparam logic [3:0] OP_RORH   = 4'd2;
  localparam logic [3:0] OP_ASCON  = 4'd4;
  localparam logic [3:0] OP_CHACHA = 4'd5;

  state_t            state_q, state_d;
  logic [3:0]        op_q;
  logic [3:0]        round_q;
  logic [ID_W-1:0]   id_q;
  logic [4:0]        rd_q;
  logic              we_q;
  logic              exc_q;
  logic [XLEN-1:0]   data_q;
  logic [31:0]       ops_q;

  logic              busy;
  logic              last;
  logic              accept;
  logic              done_hit;
  logic              ops_inc;
  logic              is_nop;
  logic              is_dp;
  logic [4:0]        n_rounds;

  always_comb begin
    is_nop = 1'b0;
    is_dp  = 1'b0;
    unique case (1'b1)
      (issue_opcode_i == OP_NOP): is_nop = 1'b1;
      (issue_opcode_i >= OP_RORH &&
       issue_opcode_i <= OP_CHACHA): is_dp = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    n_rounds = 5'd1;
    unique case (1'b1)
      (op_q == OP_ASCON):  n_rounds = 5'(ASCON_ROUNDS);
      (op_q == OP_CHACHA): n_rounds = 5'(CHACHA_ROUNDS);
      default: ;
    endcase
  end

  assign busy     = (state_q == START) || (state_q == WAIT);
  assign last     = busy && ({1'b0, round_q} == n_rounds - 5'd1);
  assign accept   = issue_valid_i && issue_ready_o;
  // Kill wins over a done arriving in the same cycle.
  assign done_hit = busy && dp_done_i && !kill_i;
  assign ops_inc  = (state_q == RESP) && result_ready_i && !kill_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = is_dp ? START : RESP;
        end
      end
      START, WAIT: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (dp_done_i) begin
          state_d = last ? RESP : START;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (kill_i || result_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      round_q <= '0;
      id_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      exc_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= issue_opcode_i;
        id_q    <= issue_id_i;
        rd_q    <= issue_rd_i;
        round_q <= '0;
        we_q    <= 1'b0;
        exc_q   <= !(is_nop || is_dp);
        data_q  <= '0;
      end else if (done_hit) begin
        if (last) begin
          data_q <= dp_result_i;
          we_q   <= 1'b1;
          exc_q  <= 1'b0;
        end else begin
          round_q <= round_q + 4'd1;
        end
      end
    end
  end

  // Only written on a handshake so an external preload is retained.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ops_q <= '0;
    end else if (ops_inc) begin
      ops_q <= ops_q + 32'd1;
    end
  end

  assign issue_ready_o  = (state_q == IDLE) && !kill_i;
  assign dp_start_o     = (state_q == START);
  assign dp_opcode_o    = op_q;
  assign dp_round_o     = round_q;
  assign dp_last_o      = last;
  assign dp_abort_o     = busy && kill_i;
  assign result_valid_o = (state_q == RESP);
  assign result_id_o    = id_q;
  assign result_rd_o    = rd_q;
  assign result_we_o    = we_q;
  assign result_exc_o   = exc_q;
  assign result_data_o  = data_q;
  assign ops_done_o     = ops_q;

endmodule

// File: tb/tb_copro_op_sequencer.sv
// Self-checking bench for copro_op_sequencer.
// Scoreboard of expected results, one task per scenario.
module tb_copro_op_sequencer;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_opcode;
  logic [2:0]  issue_id;
  logic [4:0]  issue_rd;
  logic        kill;
  logic        dp_start;
  logic [3:0]  dp_opcode;
  logic [3:0]  dp_round;
  logic        dp_last;
  logic        dp_abort;
  logic        dp_done;
  logic [31:0] dp_result;
  logic        result_valid;
  logic        result_ready;
  logic [2:0]  result_id;
  logic [4:0]  result_rd;
  logic        result_we;
  logic        result_exc;
  logic [31:0] result_data;
  logic [31:0] ops_done;

  typedef struct packed {
    logic [2:0]  id;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          failures;
  int          cyc;
  logic [31:0] exp_ops;

  copro_op_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (issue_ready),
    .issue_opcode_i (issue_opcode),
    .issue_id_i     (issue_id),
    .issue_rd_i     (issue_rd),
    .kill_i         (kill),
    .dp_start_o     (dp_start),
    .dp_opcode_o    (dp_opcode),
    .dp_round_o     (dp_round),
    .dp_last_o      (dp_last),
    .dp_abort_o     (dp_abort),
    .dp_done_i      (dp_done),
    .dp_result_i    (dp_result),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .result_id_o    (result_id),
    .result_rd_o    (result_rd),
    .result_we_o    (result_we),
    .result_exc_o   (result_exc),
    .result_data_o  (result_data),
    .ops_done_o     (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [2:0] id,
                       input logic [4:0] rd);
    issue_valid  = 1'b1;
    issue_opcode = op;
    issue_id     = id;
    issue_rd     = rd;
    step();
    issue_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_ops = 0;
    step();
    checks++;
    if ({result_valid, dp_start, dp_abort, dp_last, dp_round, dp_opcode}
        !== 12'h0) begin
      failures++;
      $display("FAIL reset_ctrl got=%h want=0",
               {result_valid, dp_start, dp_abort, dp_last,
                dp_round, dp_opcode});
    end
    checks++;
    if ({result_id, result_rd, result_we, result_exc, result_data,
         ops_done} !== 74'h0) begin
      failures++;
      $display("FAIL reset_result got=%h want=0",
               {result_id, result_rd, result_we, result_exc,
                result_data, ops_done});
    end
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", issue_ready);
    end
  endtask

  task automatic test_nop();
    exp_t e;
    exp_t got;
    result_ready = 1'b1;
    sb.push_back({3'd3, 5'd7, 1'b0, 1'b0, 32'h0});
    issue(4'd1, 3'd3, 5'd7);
    checks++;
    if (result_valid !== 1'b1) begin
      failures++;
      $display("FAIL nop_latency got=%b want=1", result_valid);
    end else begin
      e   = sb.pop_front();
      got = {result_id, result_rd, result_we, result_exc, result_data};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL nop_result got=%h want=%h", got, e);
      end
    end
    step();
    exp_ops++;
    checks++;
    if (ops_done !== exp_ops || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL nop_ops got=%0d/%b want=%0d/0",
               ops_done, result_valid, exp_ops);
    end
  endtask

  task automatic test_ror();
    exp_t e;
    exp_t got;
    result_ready = 1'b1;
    sb.push_back({3'd1, 5'd2, 1'b1, 1'b0, 32'hDEADBEEF});
    issue(4'd2, 3'd1, 5'd2);
    checks++;
    if ({dp_start, dp_last, dp_round, dp_opcode} !== 10'b11_0000_0010) begin
      failures++;
      $display("FAIL ror_start got=%b want=1100000010",
               {dp_start, dp_last, dp_round, dp_opcode});
    end
    dp_done   = 1'b1;
    dp_result = 32'hDEADBEEF;
    step();
    dp_done   = 1'b0;
    checks++;
    if (result_valid !== 1'b1) begin
      failures++;
      $display("FAIL ror_latency got=%b want=1", result_valid);
    end else begin
      e   = sb.pop_front();
      got = {result_id, result_rd, result_we, result_exc, result_data};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL ror_result got=%h want=%h", got, e);
      end
    end
    step();
    exp_ops++;
  endtask

  task automatic test_ascon();
    exp_t e;
    exp_t got;
    int   c0;
    int   s;
    int   starts;
    int   rv_cyc;
    result_ready = 1'b1;
    sb.push_back({3'd2, 5'd11, 1'b1, 1'b0, 32'h1234560C});
    c0 = cyc;
    issue(4'd4, 3'd2, 5'd11);
    starts = 0;
    s      = -10;
    rv_cyc = -1;
    for (int i = 0; i < 80 && rv_cyc < 0; i++) begin
      if (result_valid) begin
        rv_cyc = cyc;
      end else begin
        if (dp_start) begin
          checks++;
          if (dp_round !== 4'(starts) || dp_last !== (starts == 11)) begin
            failures++;
            $display("FAIL ascon_round got=%0d/%b want=%0d/%b",
                     dp_round, dp_last, starts, (starts == 11));
          end
          s = cyc;
          starts++;
        end
        dp_done   = (cyc == s + 2);
        dp_result = 32'h12345600 + 32'(starts);
        step();
      end
    end
    dp_done = 1'b0;
    checks++;
    if (starts != 12) begin
      failures++;
      $display("FAIL ascon_starts got=%0d want=12", starts);
    end
    checks++;
    if (rv_cyc != c0 + 37) begin
      failures++;
      $display("FAIL ascon_latency got=%0d want=%0d", rv_cyc - c0, 37);
    end
    if (rv_cyc >= 0) begin
      e   = sb.pop_front();
      got = {result_id, result_rd, result_we, result_exc, result_data};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL ascon_result got=%h want=%h", got, e);
      end
      step();
      exp_ops++;
    end
  endtask

  task automatic test_kill();
    int seen;
    result_ready = 1'b1;
    issue(4'd5, 3'd4, 5'd1);
    dp_done   = 1'b1;
    dp_result = 32'h1111_1111;
    step();
    checks++;
    if ({dp_start, dp_round, dp_last} !== 6'b1_0001_1) begin
      failures++;
      $display("FAIL kill_round1 got=%b want=100011",
               {dp_start, dp_round, dp_last});
    end
    kill = 1'b1;
    #1;
    checks++;
    if (dp_abort !== 1'b1 || issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL kill_abort got=%b/%b want=1/0", dp_abort, issue_ready);
    end
    step();
    kill    = 1'b0;
    dp_done = 1'b0;
    #1;
    checks++;
    if ({result_valid, dp_start, dp_abort, issue_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL kill_idle got=%b want=0001",
               {result_valid, dp_start, dp_abort, issue_ready});
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (result_valid) seen++;
      step();
    end
    checks++;
    if (seen != 0 || ops_done !== exp_ops) begin
      failures++;
      $display("FAIL kill_noresult got=%0d/%0d want=0/%0d",
               seen, ops_done, exp_ops);
    end
  endtask

  task automatic test_illegal_stall();
    exp_t e;
    exp_t got;
    int   bad;
    result_ready = 1'b0;
    sb.push_back({3'd5, 5'd9, 1'b0, 1'b1, 32'h0});
    issue(4'hF, 3'd5, 5'd9);
    e   = sb.pop_front();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      got = {result_id, result_rd, result_we, result_exc, result_data};
      if (result_valid !== 1'b1 || issue_ready !== 1'b0 || got !== e) begin
        bad++;
      end
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL illegal_stall got=%h v=%b r=%b want=%h (bad=%0d)",
               got, result_valid, issue_ready, e, bad);
    end
    result_ready = 1'b1;
    step();
    exp_ops++;
    checks++;
    if (ops_done !== exp_ops || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL illegal_ops got=%0d want=%0d", ops_done, exp_ops);
    end
  endtask

  task automatic test_wrap();
    force dut.ops_q = 32'hFFFF_FFFF;
    step();
    release dut.ops_q;
    step();
    checks++;
    if (ops_done !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_preload got=%h want=ffffffff", ops_done);
    end
    result_ready = 1'b1;
    issue(4'd1, 3'd6, 5'd3);
    step();
    checks++;
    if (ops_done !== 32'h0) begin
      failures++;
      $display("FAIL wrap_ops got=%h want=0", ops_done);
    end
  endtask

  task automatic test_reset_mid();
    result_ready = 1'b1;
    issue(4'd4, 3'd7, 5'd31);
    dp_done = 1'b1;
    step();
    dp_done = 1'b0;
    step();
    checks++;
    if ({dp_start, dp_round} !== 5'b0_0001) begin
      failures++;
      $display("FAIL rstmid_wait got=%b want=00001", {dp_start, dp_round});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({result_valid, dp_start, dp_abort, dp_last, dp_round, dp_opcode,
         result_id, result_rd, ops_done} !== 52'h0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%h want=0",
               {result_valid, dp_start, dp_abort, dp_last, dp_round,
                dp_opcode, result_id, result_rd, ops_done});
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (issue_ready !== 1'b1 || dp_abort !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle got=%b/%b want=1/0", issue_ready, dp_abort);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    cyc          = 0;
    exp_ops      = 0;
    rst          = 1'b1;
    issue_valid  = 1'b0;
    issue_opcode = 4'd0;
    issue_id     = 3'd0;
    issue_rd     = 5'd0;
    kill         = 1'b0;
    dp_done      = 1'b0;
    dp_result    = 32'h0;
    result_ready = 1'b0;
    test_reset();
    test_nop();
    test_ror();
    test_ascon();
    test_kill();
    test_illegal_stall();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
